// File: rtl/seq_arithmetic_unit.sv
// Sequential add/sub/accumulate unit with an unsigned shift-add multiplier.
// Results and flags are registered and held until the next DONE pulse.
module seq_arithmetic_unit #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [1:0]   OP,
  input  logic [W-1:0] DATA_A,
  input  logic [W-1:0] DATA_B,
  output logic [W-1:0] OUT,
  output logic [W-1:0] OUT_HI,
  output logic         CO,
  output logic         OVF,
  output logic         N,
  output logic         Z,
  output logic         BUSY,
  output logic         DONE
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_t;

  state_t         state_r, state_nxt_s;
  logic [1:0]     op_r;
  logic [W-1:0]   a_r, b_r, acc_r;
  logic [2*W-1:0] prod_r, prod_nxt_s;
  logic [CW-1:0]  cnt_r;
  logic [W:0]     mul_sum_s;
  logic           mul_last_s, accept_s;
  logic [W-1:0]   ex_lhs_s, ex_rhs_s;
  logic           ex_cin_s, ex_ovf_s;
  logic [W:0]     ex_sum_s;
  logic [W-1:0]   out_r, out_hi_r;
  logic           co_r, ovf_r, n_r, z_r, done_r;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and handshake decode
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = START && (state_r == S_IDLE);
    mul_last_s  = (state_r == S_MUL) && (cnt_r == CW'(W - 1));
    case (state_r)
      S_IDLE: begin
        if (START) begin
          state_nxt_s = (OP == 2'b10) ? S_MUL : S_EXEC;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_EXEC: state_nxt_s = S_IDLE;
      S_MUL: begin
        if (mul_last_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_MUL;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Single adder shared by ADD, SUB (A + ~B + 1) and ACC (ACC + A)
  always_comb begin
    ex_lhs_s = a_r;
    ex_rhs_s = b_r;
    ex_cin_s = 1'b0;
    case (op_r)
      2'b01: begin
        ex_lhs_s = a_r;
        ex_rhs_s = ~b_r;
        ex_cin_s = 1'b1;
      end
      2'b11: begin
        ex_lhs_s = acc_r;
        ex_rhs_s = a_r;
        ex_cin_s = 1'b0;
      end
      default: begin
        ex_lhs_s = a_r;
        ex_rhs_s = b_r;
        ex_cin_s = 1'b0;
      end
    endcase
    ex_sum_s = {1'b0, ex_lhs_s} + {1'b0, ex_rhs_s} + {{W{1'b0}}, ex_cin_s};
    // With the inverted subtrahend, one overflow rule covers add and subtract.
    ex_ovf_s = (ex_lhs_s[W-1] == ex_rhs_s[W-1]) && (ex_sum_s[W-1] != ex_lhs_s[W-1]);
  end

  // One shift-add multiplier step: add multiplicand into upper half, shift right with carry
  always_comb begin
    mul_sum_s  = {1'b0, prod_r[2*W-1:W]} + (prod_r[0] ? {1'b0, a_r} : {(W+1){1'b0}});
    prod_nxt_s = {mul_sum_s, prod_r[W-1:1]};
  end

  // Operand latch, accumulator, multiplier iteration and registered results
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_r     <= 2'b00;
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      acc_r    <= {W{1'b0}};
      prod_r   <= {(2*W){1'b0}};
      cnt_r    <= {CW{1'b0}};
      out_r    <= {W{1'b0}};
      out_hi_r <= {W{1'b0}};
      co_r     <= 1'b0;
      ovf_r    <= 1'b0;
      n_r      <= 1'b0;
      z_r      <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept_s) begin
        op_r   <= OP;
        a_r    <= DATA_A;
        b_r    <= DATA_B;
        prod_r <= {{W{1'b0}}, DATA_B};
        cnt_r  <= {CW{1'b0}};
      end else if (state_r == S_EXEC) begin
        out_r    <= ex_sum_s[W-1:0];
        out_hi_r <= {W{1'b0}};
        co_r     <= ex_sum_s[W];
        ovf_r    <= ex_ovf_s;
        n_r      <= ex_sum_s[W-1];
        z_r      <= (ex_sum_s[W-1:0] == {W{1'b0}});
        done_r   <= 1'b1;
        if (op_r == 2'b11) begin
          acc_r <= ex_sum_s[W-1:0];
        end else begin
          acc_r <= acc_r;
        end
      end else if (state_r == S_MUL) begin
        prod_r <= prod_nxt_s;
        cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        if (mul_last_s) begin
          out_r    <= prod_nxt_s[W-1:0];
          out_hi_r <= prod_nxt_s[2*W-1:W];
          co_r     <= 1'b0;
          ovf_r    <= (prod_nxt_s[2*W-1:W] != {W{1'b0}});
          n_r      <= prod_nxt_s[2*W-1];
          z_r      <= (prod_nxt_s == {(2*W){1'b0}});
          done_r   <= 1'b1;
        end else begin
          done_r <= 1'b0;
        end
      end else begin
        done_r <= 1'b0;
      end
    end
  end

  assign OUT    = out_r;
  assign OUT_HI = out_hi_r;
  assign CO     = co_r;
  assign OVF    = ovf_r;
  assign N      = n_r;
  assign Z      = z_r;
  assign DONE   = done_r;
  assign BUSY   = (state_r != S_IDLE);

endmodule

// File: tb/tb_seq_arithmetic_unit.sv
// Scoreboard bench for seq_arithmetic_unit: an arithmetic reference model predicts
// each accepted operation; a monitor checks DONE timing, results, hold and BUSY.
module tb_seq_arithmetic_unit;

  localparam int W    = 4;
  localparam int MSK  = (1 << W) - 1;
  localparam int HALF = 1 << (W - 1);

  logic         CLK = 1'b0;
  logic         RST, START;
  logic [1:0]   OP;
  logic [W-1:0] DATA_A, DATA_B;
  logic [W-1:0] OUT, OUT_HI;
  logic         CO, OVF, N, Z, BUSY, DONE;

  typedef struct packed {
    logic [W-1:0] out;
    logic [W-1:0] hi;
    logic         co;
    logic         ovf;
    logic         n;
    logic         z;
    logic [31:0]  due;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        held     = '0;
  int unsigned cyc      = 0;
  int unsigned free_cyc = 0;
  int          acc_m    = 0;
  int          n_cmp    = 0;
  int          n_bad    = 0;

  always #5 CLK = ~CLK;

  seq_arithmetic_unit #(.W(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP),
    .DATA_A(DATA_A), .DATA_B(DATA_B),
    .OUT(OUT), .OUT_HI(OUT_HI), .CO(CO), .OVF(OVF), .N(N), .Z(Z),
    .BUSY(BUSY), .DONE(DONE)
  );

  function automatic int sx(input int v);
    return (v >= HALF) ? v - (1 << W) : v;
  endfunction

  // Reference: plain integer arithmetic, signed range check for overflow
  function automatic exp_t model(input int op, input int a, input int b);
    exp_t e;
    int r, s, p;
    e = '0;
    r = 0;
    s = 0;
    case (op)
      0: begin r = a + b;     s = sx(a) + sx(b);     end
      1: begin r = a - b;     s = sx(a) - sx(b);     end
      3: begin r = acc_m + a; s = sx(acc_m) + sx(a); end
      default: begin r = 0; s = 0; end
    endcase
    if (op == 2) begin
      p     = a * b;
      e.out = W'(p & MSK);
      e.hi  = W'(p >> W);
      e.co  = 1'b0;
      e.ovf = ((p >> W) != 0);
      e.n   = (((p >> (2*W-1)) & 1) == 1);
      e.z   = (p == 0);
    end else begin
      e.out = W'(r & MSK);
      e.hi  = '0;
      e.co  = (op == 1) ? (a >= b) : (r > MSK);
      e.ovf = (s >= HALF) || (s < -HALF);
      e.n   = ((r & MSK) >= HALF);
      e.z   = ((r & MSK) == 0);
      if (op == 3) acc_m = r & MSK;
    end
    return e;
  endfunction

  // Acceptance tracker: decides from the bench's own busy window what the DUT accepts
  always @(posedge CLK) begin
    exp_t e;
    bit   busy_m;
    busy_m = (cyc < free_cyc);
    cyc    = cyc + 1;
    if (RST) begin
      sb_q.delete();
      acc_m    = 0;
      free_cyc = 0;
      held     = '0;
    end else if (START && !busy_m) begin
      e        = model(int'(OP), int'(DATA_A), int'(DATA_B));
      e.due    = cyc + ((OP == 2'b10) ? W : 1);
      free_cyc = e.due;
      sb_q.push_back(e);
    end
  end

  // Monitor: DONE exactly when due, outputs equal the latest result, BUSY matches window
  always @(negedge CLK) begin
    if (cyc != 0) begin
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        n_cmp++;
        if (DONE !== 1'b1) begin
          n_bad++;
          $display("FAIL done_missing cyc=%0d got DONE=%b want 1", cyc, DONE);
        end
        held = sb_q.pop_front();
      end else if (DONE !== 1'b0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_unexpected cyc=%0d got DONE=%b want 0", cyc, DONE);
      end
      n_cmp++;
      if ({OUT, OUT_HI, CO, OVF, N, Z} !== {held.out, held.hi, held.co, held.ovf, held.n, held.z}) begin
        n_bad++;
        $display("FAIL result cyc=%0d got OUT=%h HI=%h CO=%b OVF=%b N=%b Z=%b want OUT=%h HI=%h CO=%b OVF=%b N=%b Z=%b",
                 cyc, OUT, OUT_HI, CO, OVF, N, Z,
                 held.out, held.hi, held.co, held.ovf, held.n, held.z);
      end
      n_cmp++;
      if (BUSY !== (cyc < free_cyc)) begin
        n_bad++;
        $display("FAIL busy cyc=%0d got BUSY=%b want %b", cyc, BUSY, (cyc < free_cyc));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input int a, input int b);
    @(negedge CLK);
    START  = 1'b1;
    OP     = op;
    DATA_A = W'(a);
    DATA_B = W'(b);
    @(negedge CLK);
    START = 1'b0;
    repeat (W + 1) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST    = 1'b1;
    START  = 1'b0;
    OP     = 2'b00;
    DATA_A = '0;
    DATA_B = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    issue(2'b00, 7, 1);
    issue(2'b01, 3, 3);
    issue(2'b01, 0, 1);
    issue(2'b01, 8, 1);
    issue(2'b10, 15, 15);
    issue(2'b10, 0, 9);
    issue(2'b10, 3, 5);

    do_reset();
    repeat (4) issue(2'b11, 5, 0);
    do_reset();
    issue(2'b11, 1, 0);

    // ADD request while a MUL is busy must be dropped
    @(negedge CLK);
    START = 1'b1; OP = 2'b10; DATA_A = 4'd6; DATA_B = 4'd7;
    @(negedge CLK);
    OP = 2'b00; DATA_A = 4'd1; DATA_B = 4'd1;
    @(negedge CLK);
    START = 1'b0;
    repeat (W + 1) @(negedge CLK);

    // START held high: one ADD every two cycles
    @(negedge CLK);
    START = 1'b1; OP = 2'b00; DATA_A = 4'd2; DATA_B = 4'd3;
    repeat (8) @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset on the second busy edge of a MUL aborts it
    @(negedge CLK);
    START = 1'b1; OP = 2'b10; DATA_A = 4'hF; DATA_B = 4'hF;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (W + 2) @(negedge CLK);
    issue(2'b00, 1, 1);

    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      RST    = ($urandom_range(0, 99) == 0);
      START  = ($urandom_range(0, 2) != 0);
      OP     = 2'($urandom_range(0, 3));
      DATA_A = W'($urandom);
      DATA_B = W'($urandom);
    end
    @(negedge CLK);
    RST   = 1'b0;
    START = 1'b0;
    repeat (2 * W + 4) @(negedge CLK);

    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending results want 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
